// File: rtl/vector_dot_accumulator_if.sv
// Stream interface of the dot-product accumulator: a beat stream of lane
// products in, one reduced dot-product result out, each with valid/ready.
interface vector_dot_accumulator_if #(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] in_products;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [ACC_WIDTH-1:0]              out_sum;
    logic [CNT_WIDTH-1:0]              out_count;
    logic                              out_overflow;

    // Producer of beats and consumer of results.
    modport master (
        output in_valid, in_products, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_products, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/vector_dot_accumulator.sv
// Dot-product accumulator: reduces each product beat with an adder tree,
// accumulates beats until in_last, then holds one result until it is taken.
// Pipeline: tree register -> accumulator -> result register.
module vector_dot_accumulator #(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    vector_dot_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_FLUSH,
        ST_HOLD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   in_ready;
    logic                   accept;
    logic                   load_result;
    logic                   release_result;

    logic [ACC_WIDTH-1:0]   tree_sum;
    logic [ACC_WIDTH-1:0]   tree_q;
    logic                   tree_valid;
    logic                   tree_last;

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_next;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_next;
    logic                   overflow;
    logic                   first;
    logic                   acc_done;

    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    // Lane reduction: zero-extended lanes summed; ACC_WIDTH leaves room for the carries.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            tree_sum = tree_sum + ACC_WIDTH'(bus.in_products[DATA_WIDTH*i +: DATA_WIDTH]);
        end
    end

    // Stage 1: register the reduced beat with its valid and last flags.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q     <= '0;
            tree_valid <= 1'b0;
            tree_last  <= 1'b0;
        end else begin
            tree_valid <= accept;
            if (accept) begin
                tree_q    <= tree_sum;
                tree_last <= bus.in_last;
            end
        end
    end

    // Stage 2 arithmetic: the first beat of a vector starts from zero; the extra
    // MSB of acc_next is the carry that marks a wrap.
    always_comb begin
        acc_next   = {1'b0, (first ? '0 : acc)} + {1'b0, tree_q};
        count_next = first ? CNT_ONE : ((count == CNT_MAX) ? count : count + CNT_ONE);
    end

    // Stage 2: accumulate tree beats; acc_done flags that the last beat is in acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            first    <= 1'b1;
            acc_done <= 1'b0;
        end else if (load_result) begin
            first    <= 1'b1;
            acc_done <= 1'b0;
        end else if (release_result) begin
            overflow <= 1'b0;
        end else if (tree_valid) begin
            acc      <= acc_next[ACC_WIDTH-1:0];
            overflow <= (first ? 1'b0 : overflow) | acc_next[ACC_WIDTH];
            count    <= count_next;
            first    <= 1'b0;
            acc_done <= tree_last;
        end
    end

    // Result register: captured once per vector and held stable until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_sum      <= '0;
            bus.out_count    <= '0;
            bus.out_overflow <= 1'b0;
        end else if (load_result) begin
            bus.out_valid    <= 1'b1;
            bus.out_sum      <= acc;
            bus.out_count    <= count;
            bus.out_overflow <= overflow;
        end else if (release_result) begin
            bus.out_valid    <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and control strobes.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        load_result    = 1'b0;
        release_result = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Input closed while the last beat drains through tree and accumulator.
                if (acc_done) begin
                    load_result = 1'b1;
                    state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    release_result = 1'b1;
                    state_nxt      = ST_ACCUM;
                end
            end
            default: begin
                state_nxt = ST_ACCUM;
            end
        endcase
    end

endmodule
